ped_request: RTL

//  Pedestrian push-button front end feeding the traffic light sequencer.
//  - Synchronises and debounces the raw crossing button and latches one request.
//  - Holds ped_req until the sequencer returns ped_ack on entering its pedestrian-green phase.
//  - Drives a blinking "WAIT" lamp while a request is pending.

---
 rtl/ped_request.sv | 102 ++++++++++
 1 files changed

// File: rtl/ped_request.sv
// rtl/ped_request.sv - pedestrian button synchroniser, debouncer and request/WAIT-lamp FSM
module ped_request #(
  parameter int DEBOUNCE_CYCLES   = 16000,
  parameter int BLINK_HALF_CYCLES = 8000000
) (
  input  logic pin3_clk_16mhz,
  input  logic rst_n,
  input  logic pin9_button,
  input  logic ped_ack,
  output logic ped_req,
  output logic pin10_wait_led
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
  localparam logic [DW-1:0] DTERM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BTERM = BW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVED  = 2'b10
  } state_t;

  state_t        state, state_next;
  logic          s1, s2;
  logic          btn_db, btn_db_q;
  logic [DW-1:0] dcnt;
  logic [BW-1:0] bcnt;
  logic          blink_on;
  logic          press_evt;

  // Button is active-low, so a debounced falling edge is a fresh press.
  assign press_evt = btn_db_q & ~btn_db;

  always_ff @(posedge pin3_clk_16mhz) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      btn_db   <= 1'b1;
      btn_db_q <= 1'b1;
      dcnt     <= '0;
    end else begin
      s1       <= pin9_button;
      s2       <= s1;
      btn_db_q <= btn_db;
      if (s2 == btn_db) begin
        dcnt <= '0;
      end else if (dcnt == DTERM) begin
        btn_db <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pin3_clk_16mhz) begin
    if (!rst_n) begin
      state    <= IDLE;
      bcnt     <= '0;
      blink_on <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && press_evt) begin
        bcnt     <= '0;
        blink_on <= 1'b1;
      end else if (state == PENDING) begin
        if (bcnt == BTERM) begin
          bcnt     <= '0;
          blink_on <= ~blink_on;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next     = IDLE;
    ped_req        = 1'b0;
    pin10_wait_led = 1'b0;
    case (state)
      IDLE: begin
        state_next = press_evt ? PENDING : IDLE;
      end
      PENDING: begin
        ped_req        = 1'b1;
        pin10_wait_led = blink_on;
        state_next     = ped_ack ? SERVED : PENDING;
      end
      SERVED: begin
        // Only a released button re-arms, so a held press cannot re-request.
        state_next = btn_db ? IDLE : SERVED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
